// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM states, control bundles,
// RV32I opcode constants shared with the control unit, and the x0 register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_INIT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_LOAD_STALL = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

  // One bit per pipeline-register control pin, MSB = PC enable.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT     = 6'b001010;
  localparam ctrl_t CTRL_RUN      = 6'b110101;
  localparam ctrl_t CTRL_BUBBLE   = 6'b000111;
  localparam ctrl_t CTRL_REDIRECT = 6'b111111;
  localparam ctrl_t CTRL_FREEZE   = 6'b000000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic is_load_op(input logic [6:0] opcode);
    return opcode == OP_LOAD;
  endfunction

  function automatic logic is_redirect_op(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM status in, pipeline enables/flushes out.
// HAZARD_PERF_CNT_EN adds the two performance counter outputs.
interface pipeline_hazard_ctrl_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int CNT_W = 32)
`endif
  ;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_load;
  logic       ex_redirect;
  logic       mem_req;
  logic       mem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       mem_timeout;
  logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_timeout, state_dbg,
    input  stall_cycles, flush_events
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_timeout, state_dbg,
    output stall_cycles, flush_events
  );
`else
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_timeout, state_dbg
  );
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_load, ex_redirect, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_timeout, state_dbg
  );
`endif
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID source register produced by a load in EX.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  output logic       hazard
);
  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
  // Writes to x0 are discarded, so they never create a dependency.
  assign hazard    = ex_load && (ex_rd != REG_X0) && (rs1_match || rs2_match);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central pipeline sequencer: advance/hold/flush for PC, IF/ID, ID/EX, EX/MEM.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_WAIT_MAX      = 255,
  parameter int CNT_W             = 32
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_WAIT_MAX);

  state_t     state_reg, state_next;
  state_t     ret_state_reg, ret_state_next;
  state_t     eval_state;
  logic [1:0] stall_cnt_reg, stall_cnt_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_timeout_reg, mem_timeout_next;
  logic       hazard, memstall, watchdog_fire, eval_memstall, redirect_taken;
  ctrl_t      ctrl;

  load_use_detect u_detect (
    .id_rs1    (bus.id_rs1),
    .id_rs2    (bus.id_rs2),
    .id_use_rs1(bus.id_use_rs1),
    .id_use_rs2(bus.id_use_rs2),
    .ex_rd     (bus.ex_rd),
    .ex_load   (bus.ex_load),
    .hazard    (hazard)
  );

  assign memstall      = bus.mem_req && !bus.mem_ready;
  assign watchdog_fire = (MEM_WAIT_MAX != 0) && (state_reg == ST_MEM_WAIT) && memstall
                         && (wait_cnt_reg == WAIT_LIMIT);

  // A MEM_WAIT cycle that resolves (ready or watchdog) behaves exactly like the interrupted state.
  always_comb begin
    if ((state_reg == ST_MEM_WAIT) && (!memstall || watchdog_fire)) begin
      eval_state    = ret_state_reg;
      eval_memstall = 1'b0;
    end else begin
      eval_state    = state_reg;
      eval_memstall = memstall;
    end
  end

  always_comb begin
    ctrl             = CTRL_FREEZE;
    state_next       = state_reg;
    ret_state_next   = ret_state_reg;
    stall_cnt_next   = stall_cnt_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg || watchdog_fire;
    redirect_taken   = 1'b0;
    unique case (eval_state)
      ST_INIT: begin
        ctrl       = CTRL_INIT;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (eval_memstall) begin
          ret_state_next = ST_RUN;
          wait_cnt_next  = 8'd1;
          state_next     = ST_MEM_WAIT;
        end else if (bus.ex_redirect) begin
          ctrl           = CTRL_REDIRECT;
          redirect_taken = 1'b1;
          state_next     = ST_RUN;
        end else if (hazard) begin
          ctrl = CTRL_BUBBLE;
          if (LOAD_STALL_CYCLES > 1) begin
            stall_cnt_next = STALL_RELOAD;
            state_next     = ST_LOAD_STALL;
          end else begin
            state_next = ST_RUN;
          end
        end else begin
          ctrl       = CTRL_RUN;
          state_next = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        if (eval_memstall) begin
          ret_state_next = ST_LOAD_STALL;
          wait_cnt_next  = 8'd1;
          state_next     = ST_MEM_WAIT;
        end else if (bus.ex_redirect) begin
          ctrl           = CTRL_REDIRECT;
          redirect_taken = 1'b1;
          stall_cnt_next = 2'd0;
          state_next     = ST_RUN;
        end else begin
          ctrl           = CTRL_BUBBLE;
          stall_cnt_next = stall_cnt_reg - 2'd1;
          state_next     = (stall_cnt_reg == 2'd1) ? ST_RUN : ST_LOAD_STALL;
        end
      end
      ST_MEM_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_INIT;
      ret_state_reg   <= ST_RUN;
      stall_cnt_reg   <= 2'd0;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_state_reg   <= ret_state_next;
      stall_cnt_reg   <= stall_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.mem_timeout = mem_timeout_reg;
  assign bus.state_dbg   = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_reg;
  logic [CNT_W-1:0] flush_events_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
    end else begin
      if ((state_reg != ST_INIT) && !ctrl.pc_en && (stall_cycles_reg != '1))
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      if (redirect_taken && (flush_events_reg != '1))
        flush_events_reg <= flush_events_reg + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.flush_events = flush_events_reg;
`else
  // CNT_W only sizes the optional counters; redirect_taken only feeds them.
  localparam int unused_cnt_w = CNT_W;
  logic unused_redirect_taken;
  assign unused_redirect_taken = redirect_taken;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: two instances (1 and 3 load bubbles,
// watchdog at 8) driven with identical stimulus and checked against a cycle-level model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_req = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic u1 = 0, u2 = 0, ld = 0, redir = 0, req = 0, rdy = 1;

`ifdef HAZARD_PERF_CNT_EN
  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus1 ();
  pipeline_hazard_ctrl_if #(.CNT_W(32)) bus3 ();
`else
  pipeline_hazard_ctrl_if bus1 ();
  pipeline_hazard_ctrl_if bus3 ();
`endif

  assign bus1.id_rs1 = rs1;  assign bus1.id_rs2 = rs2;  assign bus1.ex_rd = rd;
  assign bus1.id_use_rs1 = u1;  assign bus1.id_use_rs2 = u2;  assign bus1.ex_load = ld;
  assign bus1.ex_redirect = redir;  assign bus1.mem_req = req;  assign bus1.mem_ready = rdy;
  assign bus3.id_rs1 = rs1;  assign bus3.id_rs2 = rs2;  assign bus3.ex_rd = rd;
  assign bus3.id_use_rs1 = u1;  assign bus3.id_use_rs2 = u2;  assign bus3.ex_load = ld;
  assign bus3.ex_redirect = redir;  assign bus3.mem_req = req;  assign bus3.mem_ready = rdy;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_WAIT_MAX(8), .CNT_W(32)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1));
  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_WAIT_MAX(8), .CNT_W(32)) dut3 (
    .clk(clk), .reset(rst), .bus(bus3));

  // Reference model: remaining bubbles, freeze length so far, sticky timeout.
  localparam int WD_MAX = 8;
  int   ls_cfg [2] = '{1, 3};
  bit   m_init [2];
  int   m_bub [2];
  bit   m_frozen [2];
  int   m_flen [2];
  bit   m_to [2];
  int   m_stall [2], m_flush [2], seen_stall [2], seen_flush [2];
  logic [8:0] exp_v [2];
  logic [8:0] act_v [2];
  int checks = 0;
  int errors = 0;

  task automatic model_step(input int k);
    bit stall_now, hz, dog, to_before;
    logic [5:0] c;
    logic [1:0] dbg;
    seen_stall[k] = m_stall[k];
    seen_flush[k] = m_flush[k];
    if (rst) begin
      m_init[k] = 1; m_bub[k] = 0; m_frozen[k] = 0; m_flen[k] = 0; m_to[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0; seen_stall[k] = 0; seen_flush[k] = 0;
      exp_v[k] = 9'b001010_0_00;
      return;
    end
    if (m_init[k]) begin
      m_init[k] = 0;
      exp_v[k] = {6'b001010, m_to[k], 2'd0};
      return;
    end
    stall_now = req && !rdy;
    hz = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    dbg = m_frozen[k] ? 2'd3 : ((m_bub[k] > 0) ? 2'd2 : 2'd1);
    to_before = m_to[k];
    dog = m_frozen[k] && stall_now && (m_flen[k] == WD_MAX);
    if (stall_now && !dog) begin
      c = 6'b000000;
      if (m_frozen[k]) m_flen[k]++;
      else begin m_frozen[k] = 1; m_flen[k] = 1; end
    end else begin
      m_frozen[k] = 0;
      if (dog) m_to[k] = 1;
      if (redir) begin c = 6'b111111; m_bub[k] = 0; m_flush[k]++; end
      else if (m_bub[k] > 0) begin c = 6'b000111; m_bub[k]--; end
      else if (hz) begin c = 6'b000111; m_bub[k] = ls_cfg[k] - 1; end
      else c = 6'b110101;
    end
    if (!c[5]) m_stall[k]++;
    exp_v[k] = {c, to_before, dbg};
  endtask

  task automatic apply(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic [4:0] a_rd,
                       input logic a_u1, input logic a_u2, input logic a_ld,
                       input logic a_redir, input logic a_req, input logic a_rdy);
    @(posedge clk);
    #1;
    rst = rst_req;
    rs1 = a_rs1; rs2 = a_rs2; rd = a_rd; u1 = a_u1; u2 = a_u2;
    ld = a_ld; redir = a_redir; req = a_req; rdy = a_rdy;
    @(negedge clk);
    act_v[0] = {bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_en, bus1.idex_flush,
                bus1.exmem_en, bus1.mem_timeout, bus1.state_dbg};
    act_v[1] = {bus3.pc_en, bus3.ifid_en, bus3.ifid_flush, bus3.idex_en, bus3.idex_flush,
                bus3.exmem_en, bus3.mem_timeout, bus3.state_dbg};
    model_step(0);
    model_step(1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 3) rst_req = 0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL reset dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
      if (i < 4) begin
        checks++;
        if (act_v[0] !== 9'b001010_0_00) begin
          errors++; $display("FAIL reset_init_pattern cyc%0d: got %b, want 001010000", i, act_v[0]);
        end
      end
    end
    checks++;
    if (act_v[0][8:3] !== 6'b110101) begin
      errors++; $display("FAIL reset_then_run: got %b, want 110101", act_v[0][8:3]);
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) apply(5, 9, 5, 1, 0, 1, 0, 0, 1);
      else if (i == 4) apply(0, 0, 0, 1, 1, 1, 0, 0, 1);
      else apply(1, 2, 3, 1, 1, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL load_use dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
      checks++;
      if (act_v[0][8:3] !== ((i == 0) ? 6'b000111 : 6'b110101)) begin
        errors++; $display("FAIL load_use_ls1 cyc%0d: got %b", i, act_v[0][8:3]);
      end
    end
    checks++;
    if (act_v[1][8:3] !== 6'b110101) begin
      errors++; $display("FAIL load_use_x0 dut3: got %b, want 110101", act_v[1][8:3]);
    end
    $display("test_load_use done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_redirect();
    apply(7, 7, 7, 1, 1, 1, 1, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_v[k] !== exp_v[k] || act_v[k][8:3] !== 6'b111111) begin
        errors++; $display("FAIL redirect_over_hazard dut%0d: got %b, want %b", k, act_v[k], exp_v[k]);
      end
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_v[k] !== exp_v[k]) begin
        errors++; $display("FAIL redirect_after dut%0d: got %b, want %b", k, act_v[k], exp_v[k]);
      end
    end
    $display("test_redirect done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mem_wait();
    int frozen = 0;
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 1, (i == 4));
      if (act_v[0][8] === 1'b0) frozen++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL mem_wait dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (act_v[0][1:0] !== 2'd3) begin
          errors++; $display("FAIL mem_wait_dbg cyc%0d: got %0d, want 3", i, act_v[0][1:0]);
        end
      end
    end
    checks++;
    if (frozen !== 4 || act_v[0][8] !== 1'b1) begin
      errors++; $display("FAIL mem_wait_frozen: got %0d frozen, pc_en=%b, want 4 and 1", frozen, act_v[0][8]);
    end
    $display("test_mem_wait done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_stall_mem();
    int bubbles = 0, freezes = 0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc_before;
    sc_before = bus3.stall_cycles;
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == 0) apply(5, 0, 5, 1, 0, 1, 0, 0, 1);
      else if (i == 1 || i == 2) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (i == 3) apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
      else apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
      if (act_v[1][8:3] === 6'b000111) bubbles++;
      if (act_v[1][8:3] === 6'b000000) freezes++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL load_stall_mem dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
    end
    checks++;
    if (bubbles !== 3 || freezes !== 2) begin
      errors++; $display("FAIL load_stall_mem_counts: got %0d bubbles %0d freezes, want 3 and 2", bubbles, freezes);
    end
`ifdef HAZARD_PERF_CNT_EN
    @(posedge clk); #1;
    checks++;
    if (bus3.stall_cycles - sc_before !== 32'd5) begin
      errors++; $display("FAIL perf_stall_delta: got %0d, want 5", bus3.stall_cycles - sc_before);
    end
`endif
    $display("test_load_stall_mem done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_watchdog();
    int adv_at = -1;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
      if (adv_at < 0 && act_v[0][8] === 1'b1) adv_at = i;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL watchdog dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
    end
    checks++;
    if (adv_at !== 8 || act_v[0][2] !== 1'b1 || act_v[1][2] !== 1'b1) begin
      errors++; $display("FAIL watchdog_fire: advanced at %0d timeout %b%b, want 8 and 11", adv_at, act_v[0][2], act_v[1][2]);
    end
    $display("test_watchdog done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL random dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (bus1.stall_cycles !== 32'(seen_stall[0]) || bus3.flush_events !== 32'(seen_flush[1])) begin
      errors++; $display("FAIL perf_random: stall %0d flush %0d, want %0d %0d",
                         bus1.stall_cycles, bus3.flush_events, seen_stall[0], seen_flush[1]);
    end
`endif
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    checks++;
    if (bus3.state_dbg !== 2'd0 || bus3.mem_timeout !== 1'b0 || bus3.idex_flush !== 1'b1 || bus3.pc_en !== 1'b0) begin
      errors++; $display("FAIL async_reset: dbg %0d timeout %b flush %b pc_en %b, want 0 0 1 0",
                         bus3.state_dbg, bus3.mem_timeout, bus3.idex_flush, bus3.pc_en);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) rst_req = 0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_v[k] !== exp_v[k]) begin
          errors++; $display("FAIL async_reset_seq dut%0d cyc%0d: got %b, want %b", k, i, act_v[k], exp_v[k]);
        end
      end
    end
    checks++;
    if (act_v[1] !== 9'b110101_0_01) begin
      errors++; $display("FAIL async_reset_run: got %b, want 110101001", act_v[1]);
    end
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_load_stall_mem();
    test_watchdog();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench exceeded its time budget");
    $fatal(1, "time limit");
  end
endmodule
